// File: rtl/npu_mem_pkg.sv
// Shared memory-subsystem definitions for the NPU SRAM buffer controllers.
package npu_mem_pkg;

  localparam int SRAM_B_ADDR_W = 10;
  localparam int SRAM_B_DATA_W = 8;
  localparam int SRAM_B_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } sram_ctrl_state_e;

  typedef struct packed {
    logic                     write;
    logic [SRAM_B_ADDR_W-1:0] base;
    logic [SRAM_B_ADDR_W:0]   len;
  } sram_b_cmd_t;

endpackage

// File: rtl/sram_b_rd_fifo.sv
// Two-entry read-return FIFO; the controller's issue throttle guarantees it never overflows.
module sram_b_rd_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_b_port_ctrl.sv
// Burst controller for the sram_B buffer: stream writes in, stream reads out with
// backpressure, one SRAM strobe per cycle at most.
module sram_b_port_ctrl
  import npu_mem_pkg::*;
#(
  parameter int ADDR_W = SRAM_B_ADDR_W,
  parameter int DATA_W = SRAM_B_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("sram_b_port_ctrl: only RD_LAT = 1 is supported");
  end

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  sram_ctrl_state_e  state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic              inflight_p1;
  logic [1:0]        fifo_count;
  logic              wr_beat;
  logic              rd_issue;
  logic              pop;
  logic              last_wr;
  logic              last_pop;
  logic [2:0]        occ;
  logic [2:0]        lim;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign wr_ready  = (state == ST_WRITE);
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid & rd_ready;

  // Reads outstanding plus buffered may not exceed the FIFO depth after this cycle.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight_p1};
  assign lim      = 3'd2 + {2'b00, pop};
  assign wr_beat  = (state == ST_WRITE) && wr_valid;
  assign rd_issue = (state == ST_READ) && (cnt < len_q) && (occ < lim);
  assign last_wr  = wr_beat && ((cnt + LEN_ONE) == len_q);
  assign last_pop = (state == ST_READ) && pop && (fifo_count == 2'd1)
                    && !inflight_p1 && (cnt == len_q);

  assign sram_ce   = wr_beat | rd_issue;
  assign sram_we   = wr_beat;
  assign sram_addr = (wr_beat | rd_issue) ? (base_q + cnt[ADDR_W-1:0]) : '0;
  assign sram_din  = wr_beat ? wr_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      base_q      <= '0;
      inflight_p1 <= 1'b0;
    end else begin
      // p0 -> p1: a read issued now has its data on sram_dout next cycle
      inflight_p1 <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            base_q <= cmd_base;
            len_q  <= cmd_len;
            cnt    <= '0;
            if (cmd_len == '0) state <= ST_DONE;
            else if (cmd_write) state <= ST_WRITE;
            else state <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_beat) cnt <= cnt + LEN_ONE;
          if (last_wr) state <= ST_DONE;
        end
        ST_READ: begin
          if (rd_issue) cnt <= cnt + LEN_ONE;
          if (last_pop) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_b_rd_fifo #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_p1),
    .push_data (sram_dout),
    .pop       (pop),
    .head      (rd_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_b_port_ctrl.sv
// Bench for sram_b_port_ctrl: behavioural SRAM, address-level reference memory,
// directed scenarios followed by randomized bursts.
module tb_sram_b_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_base;
  logic [10:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        done, busy;
  logic        sram_ce, sram_we;
  logic [9:0]  sram_addr;
  logic [7:0]  sram_din;
  logic [7:0]  sram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [1024];
  logic [7:0] wdat    [1024];

  always #5 clk = ~clk;

  sram_b_port_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .done      (done),
    .busy      (busy),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  function automatic logic [7:0] prior_byte(input int a);
    return 8'((a * 37 + 5) ^ (a >> 3));
  endfunction

  // Behavioural 1024x8 SRAM, one-cycle read latency, filled with a known pattern.
  bit         mem_init;
  logic [7:0] sram_mem [1024];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 1024; k++) sram_mem[k] <= prior_byte(k);
      mem_init <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      else         sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_done"},      done, 0);
    check_eq({tag, "_wr_ready"},  wr_ready, 0);
    check_eq({tag, "_rd_valid"},  rd_valid, 0);
    check_eq({tag, "_sram_ce"},   sram_ce, 0);
    check_eq({tag, "_sram_we"},   sram_we, 0);
    check_eq({tag, "_sram_addr"}, sram_addr, 0);
    check_eq({tag, "_sram_din"},  sram_din, 0);
    check_eq({tag, "_rd_data"},   rd_data, 0);
  endtask

  // gap_mode: 0 = continuous, 1 = alternate valid/gap, 2 = random gaps.
  // abort_after >= 0 pulls reset after that many beats.
  task automatic do_write(input int base, input int len, input int gap_mode, input int abort_after);
    int   i;
    int   cyc;
    logic gap;
    check_eq("wr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = base[9:0]; cmd_len = len[10:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    i = 0; cyc = 0;
    while (i < len && cyc < len * 4 + 16) begin
      if (abort_after >= 0 && i == abort_after) break;
      case (gap_mode)
        1:       gap = cyc[0];
        2:       gap = ($urandom_range(0, 2) == 0);
        default: gap = 1'b0;
      endcase
      wr_valid = !gap;
      wr_data  = gap ? 8'($urandom) : wdat[i];
      @(negedge clk);
      check_eq("wr_ready", wr_ready, 1);
      check_eq("wr_no_early_done", done, 0);
      if (!gap) begin
        check_eq("wr_ce", sram_ce, 1);
        check_eq("wr_we", sram_we, 1);
        check_eq("wr_addr", sram_addr, (base + i) % 1024);
        check_eq("wr_din", sram_din, wdat[i]);
        ref_mem[(base + i) % 1024] = wdat[i];
        i++;
      end else begin
        check_eq("wr_gap_ce", sram_ce, 0);
        check_eq("wr_gap_we", sram_we, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_valid = 1'b0;
    if (abort_after >= 0) begin
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      @(negedge clk);
      check_eq("rst_mid_no_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_no_done2", done, 0);
      check_eq("rst_mid_idle", cmd_ready, 1);
      return;
    end
    check_eq("wr_beats", i, len);
    @(negedge clk);
    check_eq("wr_done", done, 1);
    check_eq("wr_done_ce", sram_ce, 0);
    @(negedge clk);
    check_eq("wr_done_pulse", done, 0);
    check_eq("wr_ready_again", cmd_ready, 1);
  endtask

  // ready_mode: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  task automatic do_read(input int base, input int len, input int ready_mode);
    int cyc, issued, popped, ahead, max_ahead;
    int first_issue, first_valid, last_pop, done_cyc;
    check_eq("rd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = base[9:0]; cmd_len = len[10:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0; issued = 0; popped = 0; max_ahead = 0;
    first_issue = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < len * 6 + 20) begin
      case (ready_mode)
        1:       rd_ready = ((cyc % 3) == 0);
        2:       rd_ready = $urandom_range(0, 1) != 0;
        default: rd_ready = 1'b1;
      endcase
      @(negedge clk);
      if (sram_ce) begin
        check_eq("rd_we", sram_we, 0);
        check_eq("rd_addr", sram_addr, (base + issued) % 1024);
        if (first_issue < 0) first_issue = cyc;
        issued++;
      end
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (rd_valid && rd_ready) begin
        check_eq("rd_data", rd_data, ref_mem[(base + popped) % 1024]);
        popped++;
        if (popped == len) last_pop = cyc;
      end
      ahead = issued - popped;
      if (ahead > max_ahead) max_ahead = ahead;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    check_eq("rd_issued", issued, len);
    check_eq("rd_popped", popped, len);
    check_eq("rd_latency", first_valid - first_issue, 2);
    check_eq("rd_ahead_le2", (max_ahead <= 2), 1);
    check_eq("rd_done_after_last_pop", done_cyc, last_pop + 1);
    @(negedge clk);
    check_eq("rd_done_pulse", done, 0);
    check_eq("rd_ready_again", cmd_ready, 1);
  endtask

  task automatic do_zero_len(input logic wr);
    check_eq("z_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = 10'($urandom); cmd_len = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("z_done", done, 1);
    check_eq("z_ce", sram_ce, 0);
    @(negedge clk);
    check_eq("z_done_pulse", done, 0);
    check_eq("z_cmd_ready_again", cmd_ready, 1);
    check_eq("z_ce2", sram_ce, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = prior_byte(k);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) wdat[k] = 8'hA0 + 8'(k);
    do_write(0, 4, 0, -1);
    do_read(0, 4, 0);

    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    do_write(1022, 4, 0, -1);
    do_read(0, 2, 0);
    check_eq("wrap_ref0", ref_mem[0], 8'h33);

    do_read(1020, 8, 1);

    do_zero_len(1'b1);
    do_zero_len(1'b0);

    for (int k = 0; k < 10; k++) wdat[k] = 8'($urandom);
    do_write(100, 10, 0, 2);
    do_read(100, 4, 0);

    for (int k = 0; k < 3; k++) wdat[k] = 8'($urandom);
    do_write(300, 3, 1, -1);
    do_read(300, 3, 2);

    for (int it = 0; it < 24; it++) begin
      base = $urandom_range(0, 1023);
      len  = $urandom_range(1, 40);
      if ($urandom_range(0, 1) != 0) begin
        for (int k = 0; k < len; k++) wdat[k] = 8'($urandom);
        do_write(base, len, 2, -1);
      end else begin
        do_read(base, len, 2);
      end
    end

    for (int k = 0; k < 1024; k++) wdat[k] = 8'($urandom);
    do_write(512, 1024, 2, -1);
    do_read(700, 1024, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
